// File: rtl/mod_74x08_3_if.sv
// Signal bundle for the triple 2-input AND gate block: gate operands, gate
// result, capture enable and the registered outputs.
interface mod_74x08_3_if;
    logic [0:2] A;
    logic [0:2] B;
    logic [0:2] Y;
    logic       EN;
    logic [0:2] Q;
    logic       CHG;

    // The master drives the operands and enable; the slave returns the results.
    modport master (
        output A,
        output B,
        output EN,
        input  Y,
        input  Q,
        input  CHG
    );

    modport slave (
        input  A,
        input  B,
        input  EN,
        output Y,
        output Q,
        output CHG
    );
endinterface

// File: rtl/mod_74x08_3.sv
// Triple 2-input AND gate. Y is purely combinational; Q is a registered copy
// of Y, and CHG pulses for one cycle when a capture alters Q.
module mod_74x08_3 (
    input  logic [0:2] A,
    input  logic [0:2] B,
    output logic [0:2] Y,
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    output logic [0:2] Q,
    output logic       CHG
);

    // Gate path: no clock or reset in the cone, so a positional A,B,Y-only
    // instantiation behaves as a plain gate package.
    assign Y = A & B;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q   <= '0;
            CHG <= 1'b0;
        end else if (EN) begin
            Q   <= Y;
            CHG <= (Y != Q);
        end else begin
            CHG <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_74x08_3.sv
// Directed bench for mod_74x08_3: gate truth table, 4-state behaviour,
// capture/hold, change pulse and asynchronous reset.
module tb_mod_74x08_3;

    logic clk;
    logic rst;
    int unsigned passed;
    int unsigned total;

    mod_74x08_3_if bus ();

    mod_74x08_3 dut (
        .A   (bus.A),
        .B   (bus.B),
        .Y   (bus.Y),
        .CLK (clk),
        .RST (rst),
        .EN  (bus.EN),
        .Q   (bus.Q),
        .CHG (bus.CHG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check3(input string tag, input logic [0:2] obs, input logic [0:2] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.EN = 1'b0;
        bus.A  = 3'b000;
        bus.B  = 3'b000;

        #20;
        bus.A = 3'b111; bus.B = 3'b111;
        #20;
        check3("y_all_ones", bus.Y, 3'b111);
        check3("q_in_reset", bus.Q, 3'b000);
        check1("chg_in_reset", bus.CHG, 1'b0);

        bus.A = 3'b000; bus.B = 3'b111; #1;
        check3("y_a_zero", bus.Y, 3'b000);
        bus.A = 3'b111; bus.B = 3'b000; #1;
        check3("y_b_zero", bus.Y, 3'b000);
        bus.A = 3'b000; bus.B = 3'b000; #1;
        check3("y_both_zero", bus.Y, 3'b000);
        bus.A = 3'b100; bus.B = 3'b100; #1;
        check3("y_bit0", bus.Y, 3'b100);
        bus.A = 3'b010; bus.B = 3'b010; #1;
        check3("y_bit1", bus.Y, 3'b010);
        bus.A = 3'b001; bus.B = 3'b001; #1;
        check3("y_bit2", bus.Y, 3'b001);
        bus.A = 3'b110; bus.B = 3'b011; #1;
        check3("y_mixed", bus.Y, 3'b010);
        bus.A = 3'b101; bus.B = 3'bxx1; #1;
        check3("y_4state", bus.Y, 3'bx01);

        // Reset held with all-ones operands, then release and capture.
        bus.A = 3'b111; bus.B = 3'b111; #1;
        check3("rst_y_tracks", bus.Y, 3'b111);
        check3("rst_q_clear", bus.Q, 3'b000);
        check1("rst_chg_clear", bus.CHG, 1'b0);
        @(negedge clk);
        rst = 1'b0; bus.EN = 1'b1;
        @(posedge clk); #1;
        check3("first_cap_q", bus.Q, 3'b111);
        check1("first_cap_chg", bus.CHG, 1'b1);
        @(posedge clk); #1;
        check3("steady_q", bus.Q, 3'b111);
        check1("steady_chg", bus.CHG, 1'b0);

        // Hold with EN low while Y changes.
        @(negedge clk);
        bus.EN = 1'b0; bus.A = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check3("hold_q", bus.Q, 3'b111);
            check1("hold_chg", bus.CHG, 1'b0);
            check3("hold_y", bus.Y, 3'b000);
        end
        @(negedge clk);
        bus.EN = 1'b1;
        @(posedge clk); #1;
        check3("recap_q", bus.Q, 3'b000);
        check1("recap_chg", bus.CHG, 1'b1);

        // Mid-cycle asynchronous reset.
        @(negedge clk);
        bus.A = 3'b101; bus.B = 3'b111;
        @(posedge clk); #1;
        check3("pre_async_q", bus.Q, 3'b101);
        check1("pre_async_chg", bus.CHG, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check3("async_q", bus.Q, 3'b000);
        check1("async_chg", bus.CHG, 1'b0);
        check3("async_y", bus.Y, 3'b101);

        // Release with Y equal to the reset value: capture gives no change.
        @(negedge clk);
        rst = 1'b0; bus.A = 3'b000;
        @(posedge clk); #1;
        check3("post_rst_q", bus.Q, 3'b000);
        check1("post_rst_chg", bus.CHG, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mod_74x08_3.md
MOD_74X08_3 -- requirements
Module: mod_74x08_3

Interface
REQ-001 Parameters: none; gate count fixed at 3, bit range [0:2] with bit 0 most significant.
REQ-002 CLK  input  1  system clock, rising-edge active; the single clock of the block.
REQ-003 RST  input  1  reset, asynchronous, active-high; clears registered state only.
REQ-004 A  input  [0:2]  gate input A per channel; A[i] feeds gate i.
REQ-005 B  input  [0:2]  gate input B per channel; B[i] feeds gate i.
REQ-006 Y  output  [0:2]  combinational AND result per channel.
REQ-007 EN  input  1  capture enable for Q; sampled on CLK rising edge.
REQ-008 Q  output  [0:2]  registered copy of Y.
REQ-009 CHG  output  1  registered one-cycle flag: captured value differs from the prior Q.
REQ-010 Port declaration order SHALL be A, B, Y, CLK, RST, EN, Q, CHG, so that a positional A,B,Y-only instantiation binds correctly and leaves the remaining ports unconnected.
REQ-011 Unconnected CLK/RST/EN SHALL NOT affect Y.

Function
REQ-012 Y[i] SHALL equal A[i] AND B[i] for i = 0..2, purely combinational, with no clock or reset dependence.
REQ-013 Y SHALL settle within one simulation delta of any A/B change; no inferred latches or storage on the Y path.
REQ-014 Channels SHALL be independent: a change on A[i] or B[i] SHALL NOT affect Y[j] for j != i.
REQ-015 X/Z on an input SHALL follow standard 4-state AND semantics: 0 AND x = 0, 1 AND x = x.
REQ-016 On a CLK rising edge with RST low and EN high, Q SHALL load Y; latency from stable A/B to Q is one clock.
REQ-017 On a CLK rising edge with RST low and EN low, Q SHALL hold its value.
REQ-018 On a CLK rising edge with RST low and EN high, CHG SHALL become 1 when Y != Q (pre-edge value) and 0 otherwise.
REQ-019 On a CLK rising edge with RST low and EN low, CHG SHALL become 0.
REQ-020 CHG SHALL be a single-cycle pulse per detected change; a constant Y with EN held high SHALL produce CHG = 0 from the second edge onward.

Reset
REQ-021 While RST is high, Q SHALL be 3'b000 and CHG SHALL be 0, asserted immediately and independent of CLK.
REQ-022 RST SHALL NOT affect Y; Y keeps tracking A AND B during reset.
REQ-023 On RST deassertion, the first CLK edge with EN high SHALL load Y into Q and set CHG to 1 if Y != 3'b000.
REQ-024 If RST asserts mid-cycle, all registered state SHALL be discarded; no pending capture survives reset.

Verification
REQ-025 A=111, B=111, wait 20 time units -> Y=111 (nonzero).
REQ-026 A=000, B=111 -> Y=000; then A=111, B=000 -> Y=000.
REQ-027 A=000, B=000 -> Y=000; then each single-bit pattern A=B=100, 010, 001 -> Y equals that pattern, other bits 0.
REQ-028 RST=1 with A=B=111 -> Q=000, CHG=0, Y=111; release RST, EN=1, one CLK edge -> Q=111, CHG=1; next edge -> Q=111, CHG=0.
REQ-029 EN=0 with Q=111, A=000, three CLK edges -> Q stays 111, CHG=0, Y=000; EN=1, one edge -> Q=000, CHG=1.
REQ-030 Assert RST asynchronously between CLK edges while Q=101 -> Q=000 and CHG=0 before the next edge.
